// File: rtl/bcd_seq_conv_if.sv
// Handshake and result bundle between the arithmetic datapath and the BCD converter.
// master = requester (datapath / bench), slave = converter.
interface bcd_seq_conv_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  overflow;

  modport master (
    output start, bin,
    input  ready, busy, done, bcd, sign, overflow
  );

  modport slave (
    input  start, bin,
    output ready, busy, done, bcd, sign, overflow
  );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// optional two's-complement input, saturating to all nines on overflow.
//
//   state | meaning
//   IDLE  | ready for a new operand; start loads it
//   SHIFT | one double-dabble step per cycle, W cycles
//   DONE  | results just published, done pulse for one cycle
module bcd_seq_conv #(
  parameter int W      = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seq_conv_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    opnd;
  logic [BW-1:0]   dig;
  logic            ovf_acc;
  logic            sign_pend;

  logic [W-1:0]    load_val;
  logic            load_sign;
  logic [BW-1:0]   dig_adj;
  logic [BW-1:0]   dig_shift;
  logic            shift_out;
  logic            last_shift;
  logic            ovf_final;

  // Negative operands are converted as magnitude; -2^(W-1) maps to 2^(W-1),
  // which still fits in W unsigned bits.
  always_comb begin
    load_val  = bus.bin;
    load_sign = 1'b0;
    if (SIGNED && bus.bin[W-1]) begin
      load_val  = -bus.bin;
      load_sign = 1'b1;
    end
  end

  always_comb begin
    dig_adj = dig;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig[4*k +: 4] >= 4'd5) begin
        dig_adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
      end
    end
    dig_shift  = {dig_adj[BW-2:0], opnd[W-1]};
    shift_out  = dig_adj[BW-1];
    last_shift = (cnt == CW'(W - 1));
    ovf_final  = ovf_acc | shift_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (last_shift) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      opnd         <= '0;
      dig          <= '0;
      ovf_acc      <= 1'b0;
      sign_pend    <= 1'b0;
      bus.bcd      <= '0;
      bus.sign     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opnd      <= load_val;
            sign_pend <= load_sign;
            dig       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          dig  <= dig_shift;
          opnd <= opnd << 1;
          cnt  <= cnt + CW'(1);
          if (shift_out) begin
            ovf_acc <= 1'b1;
          end
          // The final step's carry-out must count toward the published overflow.
          if (last_shift) begin
            bus.bcd      <= ovf_final ? {DIGITS{4'h9}} : dig_shift;
            bus.sign     <= sign_pend;
            bus.overflow <= ovf_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: three configurations, table-driven jobs
// with a per-instance expected-result queue, plus abort and ignored-start sequences.
module tb_bcd_seq_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_seq_conv_if #(.W(16), .DIGITS(5)) if0 ();
  bcd_seq_conv_if #(.W(8),  .DIGITS(3)) if1 ();
  bcd_seq_conv_if #(.W(8),  .DIGITS(2)) if2 ();

  bcd_seq_conv #(.W(16), .DIGITS(5), .SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bcd_seq_conv #(.W(8),  .DIGITS(3), .SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  bcd_seq_conv #(.W(8),  .DIGITS(2), .SIGNED(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dn0 = 0, dn1 = 0, dn2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] bin;
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic on_done(input int d, input logic [19:0] bcd, input logic sg, input logic ov,
                         input logic rdy, input int w);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (qs == 0) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_unexpected_done actual=1 required=0", d);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("dut%0d_bcd", d), 32'(bcd), 32'(e.bcd));
      chk($sformatf("dut%0d_sign", d), 32'(sg), 32'(e.sign));
      chk($sformatf("dut%0d_overflow", d), 32'(ov), 32'(e.ovf));
      chk($sformatf("dut%0d_latency", d), 32'(cyc - e.acc), 32'(w));
      chk($sformatf("dut%0d_ready_in_done", d), 32'(rdy), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if0.done === 1'b1) begin
        dn0++;
        on_done(0, if0.bcd, if0.sign, if0.overflow, if0.ready, 16);
      end
      if (if1.done === 1'b1) begin
        dn1++;
        on_done(1, 20'(if1.bcd), if1.sign, if1.overflow, if1.ready, 8);
      end
      if (if2.done === 1'b1) begin
        dn2++;
        on_done(2, 20'(if2.bcd), if2.sign, if2.overflow, if2.ready, 8);
      end
    end
  end

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return if0.ready;
      1:       return if1.ready;
      default: return if2.ready;
    endcase
  endfunction

  task automatic set_in(input int d, input logic s, input logic [31:0] b);
    case (d)
      0:       begin if0.start = s; if0.bin = b[15:0]; end
      1:       begin if1.start = s; if1.bin = b[7:0];  end
      default: begin if2.start = s; if2.bin = b[7:0];  end
    endcase
  endtask

  // Waits for ready, pulses start for one accepting edge, then records the expectation.
  task automatic drive(input int d, input logic [31:0] b, input logic [19:0] ebcd,
                       input logic es, input logic eo, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (rdy_of(d) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now($sformatf("dut%0d_ready_wait", d));
      return;
    end
    set_in(d, 1'b1, b);
    @(posedge clk);
    #1;
    set_in(d, 1'b0, b);
    if (push) begin
      e.bcd  = ebcd;
      e.sign = es;
      e.ovf  = eo;
      e.acc  = cyc;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("drain_done_wait");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];
  int   d0;

  initial begin
    vecs[0]  = '{0, 32'hFFFF, 20'h65535, 1'b0, 1'b0};
    vecs[1]  = '{0, 32'd0,    20'h00000, 1'b0, 1'b0};
    vecs[2]  = '{0, 32'd12345, 20'h12345, 1'b0, 1'b0};
    vecs[3]  = '{0, 32'd9,    20'h00009, 1'b0, 1'b0};
    vecs[4]  = '{1, 32'h80,   20'h00128, 1'b1, 1'b0};
    vecs[5]  = '{1, 32'hF9,   20'h00007, 1'b1, 1'b0};
    vecs[6]  = '{1, 32'h7F,   20'h00127, 1'b0, 1'b0};
    vecs[7]  = '{2, 32'd200,  20'h00099, 1'b0, 1'b1};
    vecs[8]  = '{2, 32'd99,   20'h00099, 1'b0, 1'b0};
    vecs[9]  = '{2, 32'd100,  20'h00099, 1'b0, 1'b1};
    vecs[10] = '{0, 32'd9999, 20'h09999, 1'b0, 1'b0};
    vecs[11] = '{2, 32'd0,    20'h00000, 1'b0, 1'b0};

    set_in(0, 1'b0, 32'd0);
    set_in(1, 1'b0, 32'd0);
    set_in(2, 1'b0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",    32'(if0.ready),    32'd1);
    chk("rst_busy",     32'(if0.busy),     32'd0);
    chk("rst_done",     32'(if0.done),     32'd0);
    chk("rst_bcd",      32'(if0.bcd),      32'd0);
    chk("rst_sign",     32'(if0.sign),     32'd0);
    chk("rst_overflow", 32'(if0.overflow), 32'd0);
    chk("rst_ready1",   32'(if1.ready),    32'd1);
    chk("rst_ready2",   32'(if2.ready),    32'd1);

    // Jobs on the same instance run back to back; different instances overlap.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].d, vecs[i].bin, vecs[i].bcd, vecs[i].sign, vecs[i].ovf, 1'b1);
    end
    wait_drain();
    chk("table_done_count0", 32'(dn0), 32'd5);
    chk("table_done_count1", 32'(dn1), 32'd3);
    chk("table_done_count2", 32'(dn2), 32'd4);

    // start pulsed during the conversion must be ignored
    d0 = dn0;
    drive(0, 32'd500, 20'h00500, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("ign_ready_low", 32'(if0.ready), 32'd0);
      if (i >= 3 && i <= 8) set_in(0, 1'b1, 32'd777);
      else                  set_in(0, 1'b0, 32'd777);
    end
    wait_drain();
    repeat (30) @(negedge clk);
    chk("ign_single_done", 32'(dn0 - d0), 32'd1);
    chk("ign_ready_after", 32'(if0.ready), 32'd1);
    chk("ign_bcd_held",    32'(if0.bcd),   32'h00500);

    // reset in the middle of a conversion aborts it silently
    drive(0, 32'd4321, 20'h04321, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(if0.ready), 32'd1);
    chk("abort_busy",  32'(if0.busy),  32'd0);
    chk("abort_bcd",   32'(if0.bcd),   32'd0);
    chk("abort_done",  32'(if0.done),  32'd0);
    d0 = dn0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(dn0 - d0), 32'd0);
    drive(0, 32'd4321, 20'h04321, 1'b0, 1'b0, 1'b1);
    wait_drain();
    chk("rerun_bcd_held", 32'(if0.bcd), 32'h04321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
